dac_driver_ctrl: RTL and testbench

- Sequencing controller for the DAC driver cell (8 binary + 17 thermometric complementary control lines, active-low power-down `pdb`).
- Runs the power-up and power-down sequence for the cell.
- Accepts DAC codes over a valid/ready handshake and splits each code into a binary LSB field and a 17-unit thermometric field.
- Optionally rotates thermometric unit selection by data-weighted averaging (DWA). All driver-cell control lines are registered.

---
 rtl/dac_drv_pkg.sv | 14 +
 rtl/therm_dwa_decoder.sv | 33 +++
 rtl/dac_driver_ctrl.sv | 124 ++++++++++++
 tb/tb_dac_driver_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_drv_pkg.sv
// Shared constants, FSM state type and saturation test for the DAC driver controller.
package dac_drv_pkg;
  localparam int NUM_BIN   = 8;
  localparam int NUM_THERM = 17;
  localparam int CODE_W    = 13;
  localparam int MAX_CODE  = 4607;

  typedef enum logic [1:0] {OFF, PWR_UP, ACTIVE, PWR_DN} state_t;

  // A thermometric count above 17 always implies a code above MAX_CODE; both are tested for clarity.
  function automatic logic sat_code(input logic [CODE_W-1:0] code);
    return (code[CODE_W-1:NUM_BIN] > 5'(NUM_THERM)) || (code > CODE_W'(MAX_CODE));
  endfunction
endpackage

// File: rtl/therm_dwa_decoder.sv
// Converts a thermometric count into a 17-unit selection mask, optionally rotated by the DWA pointer.
module therm_dwa_decoder
  import dac_drv_pkg::*;
#(
  parameter bit DWA_EN = 1'b1
) (
  input  logic [4:0]           n,
  input  logic [4:0]           ptr,
  output logic [NUM_THERM-1:0] mask,
  output logic [4:0]           ptr_next
);
  logic [NUM_THERM-1:0] fill;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_THERM; gi++) begin : g_fill
      assign fill[gi] = (n > 5'(gi));
    end

    if (DWA_EN) begin : g_dwa
      logic [2*NUM_THERM-1:0] shifted;
      logic [5:0]             sum;
      // Rotate left by ptr: bits pushed past the top wrap into the low half.
      assign shifted  = {{NUM_THERM{1'b0}}, fill} << ptr;
      assign mask     = shifted[NUM_THERM-1:0] | shifted[2*NUM_THERM-1:NUM_THERM];
      assign sum      = {1'b0, ptr} + {1'b0, n};
      assign ptr_next = (sum >= 6'(NUM_THERM)) ? 5'(sum - 6'(NUM_THERM)) : sum[4:0];
    end else begin : g_fix
      assign mask     = fill;
      assign ptr_next = ptr;
    end
  endgenerate
endmodule

// File: rtl/dac_driver_ctrl.sv
// Power sequencing and code registration for the DAC driver cell (binary + 17-unit thermometric lines).
module dac_driver_ctrl
  import dac_drv_pkg::*;
#(
  parameter int PU_CYCLES = 16,
  parameter int PD_CYCLES = 8,
  parameter bit DWA_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CODE_W-1:0]    code_in,
  input  logic                 code_valid,
  output logic                 code_ready,
  output logic [NUM_BIN-1:0]   datain,
  output logic [NUM_BIN-1:0]   datainb,
  output logic [NUM_THERM-1:0] datatherm,
  output logic [NUM_THERM-1:0] datathermb,
  output logic                 pdb,
  output logic                 active,
  output logic                 sat_flag
);
  localparam int MAX_CYC = (PU_CYCLES > PD_CYCLES) ? PU_CYCLES : PD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PU_LAST = CNT_W'(PU_CYCLES - 1);
  localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PD_CYCLES - 1);

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [4:0]           ptr_reg;
  logic [NUM_BIN-1:0]   datain_reg;
  logic [NUM_THERM-1:0] datatherm_reg;
  logic                 pdb_reg;
  logic                 active_reg;
  logic                 sat_reg;

  logic                 sat;
  logic [4:0]           n_sel;
  logic [NUM_BIN-1:0]   b_sel;
  logic [NUM_THERM-1:0] mask;
  logic [4:0]           ptr_next;

  assign sat   = sat_code(code_in);
  assign n_sel = sat ? 5'(NUM_THERM) : code_in[CODE_W-1:NUM_BIN];
  assign b_sel = sat ? {NUM_BIN{1'b1}} : code_in[NUM_BIN-1:0];

  therm_dwa_decoder #(.DWA_EN(DWA_EN)) u_dec (
    .n        (n_sel),
    .ptr      (ptr_reg),
    .mask     (mask),
    .ptr_next (ptr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= OFF;
      cnt_reg       <= '0;
      ptr_reg       <= '0;
      datain_reg    <= '0;
      datatherm_reg <= '0;
      pdb_reg       <= 1'b0;
      active_reg    <= 1'b0;
      sat_reg       <= 1'b0;
    end else begin
      case (state_reg)
        OFF: begin
          ptr_reg <= '0;
          if (en) begin
            state_reg <= PWR_UP;
            pdb_reg   <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        PWR_UP: begin
          if (!en) begin
            state_reg <= PWR_DN;
            cnt_reg   <= '0;
          end else if (cnt_reg == PU_LAST) begin
            state_reg  <= ACTIVE;
            active_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ACTIVE: begin
          if (!en) begin
            // Leaving ACTIVE clears the lines at the same edge so the cell never sees a stale code.
            state_reg     <= PWR_DN;
            cnt_reg       <= '0;
            active_reg    <= 1'b0;
            datain_reg    <= '0;
            datatherm_reg <= '0;
            sat_reg       <= 1'b0;
          end else if (code_valid) begin
            datain_reg    <= b_sel;
            datatherm_reg <= mask;
            ptr_reg       <= ptr_next;
            sat_reg       <= sat;
          end else begin
            sat_reg <= 1'b0;
          end
        end
        PWR_DN: begin
          if (cnt_reg == PD_LAST) begin
            state_reg <= OFF;
            pdb_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= OFF;
      endcase
    end
  end

  assign code_ready = (state_reg == ACTIVE) & en;
  assign datain     = datain_reg;
  assign datainb    = ~datain_reg;
  assign datatherm  = datatherm_reg;
  assign datathermb = ~datatherm_reg;
  assign pdb        = pdb_reg;
  assign active     = active_reg;
  assign sat_flag   = sat_reg;
endmodule

// File: tb/tb_dac_driver_ctrl.sv
// Scoreboard bench: DWA and fixed-fill instances share stimulus; a monitor checks each accepted code.
`timescale 1ns/1ps
module tb_dac_driver_ctrl;
  localparam int PU = 16;
  localparam int PD = 8;

  logic        clk = 1'b0;
  logic        rst, en, code_valid;
  logic [12:0] code_in;

  logic        d_code_ready, d_pdb, d_active, d_sat;
  logic [7:0]  d_datain, d_datainb;
  logic [16:0] d_datatherm, d_datathermb;
  logic        f_code_ready, f_pdb, f_active, f_sat;
  logic [7:0]  f_datain, f_datainb;
  logic [16:0] f_datatherm, f_datathermb;

  always #5 clk = ~clk;

  dac_driver_ctrl #(.PU_CYCLES(PU), .PD_CYCLES(PD), .DWA_EN(1'b1)) u_dwa (
    .clk(clk), .rst(rst), .en(en), .code_in(code_in), .code_valid(code_valid),
    .code_ready(d_code_ready), .datain(d_datain), .datainb(d_datainb),
    .datatherm(d_datatherm), .datathermb(d_datathermb), .pdb(d_pdb),
    .active(d_active), .sat_flag(d_sat)
  );

  dac_driver_ctrl #(.PU_CYCLES(PU), .PD_CYCLES(PD), .DWA_EN(1'b0)) u_fix (
    .clk(clk), .rst(rst), .en(en), .code_in(code_in), .code_valid(code_valid),
    .code_ready(f_code_ready), .datain(f_datain), .datainb(f_datainb),
    .datatherm(f_datatherm), .datathermb(f_datathermb), .pdb(f_pdb),
    .active(f_active), .sat_flag(f_sat)
  );

  typedef struct {
    logic [7:0]  din;
    logic [16:0] tdwa;
    logic [16:0] tfix;
    logic        sat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          mdl_ptr = 0;
  bit          hold_chk = 1'b0;
  logic [7:0]  last_din = '0;
  logic [16:0] last_tdwa = '0;
  logic [16:0] last_tfix = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: unit i of n goes to slot (ptr+i) mod 17, codes above 4607 clip to full scale.
  function automatic exp_t model(input logic [12:0] code);
    exp_t e;
    int n, b;
    if (int'(code) > 4607) begin
      n = 17; b = 255; e.sat = 1'b1;
    end else begin
      n = int'(code) / 256; b = int'(code) % 256; e.sat = 1'b0;
    end
    e.din  = 8'(b);
    e.tfix = 17'((1 << n) - 1);
    e.tdwa = '0;
    for (int i = 0; i < n; i++) e.tdwa[(mdl_ptr + i) % 17] = 1'b1;
    mdl_ptr = (mdl_ptr + n) % 17;
    return e;
  endfunction

  // Monitor: after any edge that completed a handshake, pop and compare; otherwise outputs must hold.
  initial begin
    bit   hs = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      chk("cmpl_bin_dwa",   {24'd0, d_datain ^ d_datainb}, 32'hFF);
      chk("cmpl_therm_dwa", {15'd0, d_datatherm ^ d_datathermb}, 32'h1FFFF);
      chk("cmpl_bin_fix",   {24'd0, f_datain ^ f_datainb}, 32'hFF);
      chk("cmpl_therm_fix", {15'd0, f_datatherm ^ f_datathermb}, 32'h1FFFF);
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          $display("txn din=%02h tdwa=%05h tfix=%05h sat=%0d", d_datain, d_datatherm, f_datatherm, d_sat);
          chk("datain",        d_datain,    e.din);
          chk("datain_fix",    f_datain,    e.din);
          chk("datatherm_dwa", d_datatherm, e.tdwa);
          chk("datatherm_fix", f_datatherm, e.tfix);
          chk("sat_flag",      d_sat,       e.sat);
          chk("sat_flag_fix",  f_sat,       e.sat);
          last_din = e.din; last_tdwa = e.tdwa; last_tfix = e.tfix;
        end
      end else begin
        chk("sat_idle", {d_sat, f_sat}, 2'b00);
        if (hold_chk) begin
          chk("hold_din",  d_datain,    last_din);
          chk("hold_tdwa", d_datatherm, last_tdwa);
          chk("hold_tfix", f_datatherm, last_tfix);
        end
      end
      hs = code_valid && d_code_ready && !rst;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [12:0] c, input bit v);
    code_in = c; code_valid = v;
    if (v) exp_q.push_back(model(c));
    #1;
    chk("code_ready_active", {d_code_ready, f_code_ready}, 2'b11);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_din"},   {d_datain, f_datain}, 16'd0);
    chk({tag, "_therm"}, {15'd0, d_datatherm | f_datatherm}, 32'd0);
  endtask

  task automatic power_up(input int stop_after);
    en = 1'b1; code_valid = 1'b0; #1;
    chk("pdb_before_up", d_pdb, 1'b0);
    tick();
    chk("pdb_rise", {d_pdb, f_pdb}, 2'b11);
    for (int j = 1; j <= PU && (stop_after == 0 || j <= stop_after); j++) begin
      tick();
      chk("code_ready_pu", d_code_ready, (j == PU));
      chk("active_pu", d_active, (j == PU));
      check_zero("pu_zero");
    end
    last_din = '0; last_tdwa = '0; last_tfix = '0;
  endtask

  task automatic power_down(input bit early_en);
    hold_chk = 1'b0;
    en = 1'b0; code_valid = 1'b1; code_in = 13'($urandom); #1;
    chk("code_ready_drop", d_code_ready, 1'b0);
    tick();
    check_zero("pd_zero0");
    chk("pdb_pd0", d_pdb, 1'b1);
    chk("active_pd0", d_active, 1'b0);
    for (int j = 1; j <= PD; j++) begin
      if (early_en && j == PD / 2) en = 1'b1;
      tick();
      chk("pdb_pd", d_pdb, (j < PD));
      check_zero("pd_zero");
    end
    mdl_ptr = 0;
    code_valid = 1'b0;
  endtask

  task automatic reset_mid();
    hold_chk = 1'b0; code_valid = 1'b0; en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_pdb", {d_pdb, f_pdb}, 2'b00);
    chk("rst_active", {d_active, f_active, d_sat}, 3'b000);
    check_zero("rst_zero");
    chk("rst_datainb", d_datainb, 8'hFF);
    chk("rst_datathermb", d_datathermb, 17'h1FFFF);
    mdl_ptr = 0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_random(input int cycles);
    logic [12:0] c;
    hold_chk = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      case ($urandom_range(0, 9))
        0:       c = 13'($urandom);
        1:       c = 13'd4607;
        2:       c = 13'd4608;
        3:       c = 13'd0;
        default: c = {5'($urandom_range(0, 17)), 8'($urandom)};
      endcase
      drive(c, $urandom_range(0, 3) != 0);
    end
    code_valid = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] dir_codes [8];
    dir_codes = '{13'h0500, 13'h0500, 13'h0A00, 13'h0CAA, 13'h1FFF, 13'h1200, 13'h11FF, 13'h0000};
    rst = 1'b1; en = 1'b0; code_valid = 1'b0; code_in = '0;
    #3;
    chk("init_pdb", {d_pdb, d_active, d_sat, d_code_ready}, 4'b0000);
    chk("init_datainb", d_datainb, 8'hFF);
    chk("init_datathermb", d_datathermb, 17'h1FFFF);
    check_zero("init_zero");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("off_holds", d_pdb, 1'b0);

    power_up(0);
    hold_chk = 1'b1;
    foreach (dir_codes[i]) drive(dir_codes[i], 1'b1);
    drive(13'h1ABC, 1'b0);
    power_down(1'b0);

    power_up(0);
    run_random(150);
    power_down(1'b1);

    power_up(0);
    run_random(150);
    reset_mid();

    power_up(6);
    reset_mid();

    power_up(0);
    run_random(100);
    power_down(1'b0);
    power_up(5);
    power_down(1'b0);

    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
